fault_inject_sched: RTL and testbench

Sequencer for the fault generator's LFSR address source. It seeds the `lfsr` instance, steps it once per fault, and captures each output as a fault address. Addresses go to the downstream fault injector over a valid/ready handshake, with a programmable count and inter-fault gap. It sits between the config/CSR side and the `lfsr` + injector pair.

---
 rtl/fault_gen_pkg.sv | 23 ++
 rtl/fault_gap_timer.sv | 28 ++
 rtl/fault_inject_sched.sv | 161 ++++++++++++++++
 tb/tb_fault_inject_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fault_gen_pkg.sv
// Shared types for the fault-generator blocks: scheduler state encoding,
// default widths and the address handshake record.
package fault_gen_pkg;

    localparam int FG_N_BITS = 8;
    localparam int FG_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STEP,
        CAPT,
        ISSUE,
        GAP,
        DONE
    } sched_state_e;

    typedef struct packed {
        logic                 valid;
        logic [FG_N_BITS-1:0] addr;
    } fault_hs_t;

endpackage

// File: rtl/fault_gap_timer.sv
// Loadable down-counter used to space out fault issues.
// expired is high during the final counted cycle, so a load of G spans G cycles.
module fault_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/fault_inject_sched.sv
// Sequencer that seeds/steps the external lfsr and issues each stepped value as a
// fault address. Define FAULT_ADDR_MASK_EN to mask addresses and skip all-zero ones.
module fault_inject_sched
    import fault_gen_pkg::*;
#(
    parameter int                N_bits    = FG_N_BITS,
    parameter int                CNT_W     = FG_CNT_W,
    parameter logic [N_bits-1:0] ADDR_MASK = {N_bits{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              cfg_start_i,
    input  logic              cfg_abort_i,
    input  logic [N_bits-1:0] cfg_seed_i,
    input  logic [CNT_W-1:0]  cfg_num_i,
    input  logic [CNT_W-1:0]  cfg_gap_i,
    output logic              lfsr_start_o,
    output logic              lfsr_en_o,
    output logic [N_bits-1:0] lfsr_seed_o,
    input  logic [N_bits-1:0] lfsr_out_i,
`ifdef FAULT_ADDR_MASK_EN
    output logic              skip_cap_o,
`endif
    output logic              fault_valid_o,
    output logic [N_bits-1:0] fault_addr_o,
    input  logic              fault_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  fault_cnt_o
);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  num_q, gap_q, cnt_next;
    logic [N_bits-1:0] addr_capt;
    logic              start_ok, cnt_inc, capt, gap_load, gap_tick, gap_expired;

    assign start_ok = (state_q == IDLE) && cfg_start_i;
    assign cnt_next = fault_cnt_o + CNT_W'(1);

`ifdef FAULT_ADDR_MASK_EN
    localparam logic [N_bits:0] SKIP_LAST = {1'b0, {N_bits{1'b1}}};
    logic [N_bits:0] skip_cnt_q;
    logic            skip;
    assign addr_capt = lfsr_out_i & ADDR_MASK;
`else
    logic unused_mask_bits;
    assign unused_mask_bits = ^ADDR_MASK;
    assign addr_capt = lfsr_out_i;
`endif

    fault_gap_timer #(.W(CNT_W)) u_gap (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .load     (gap_load),
        .load_val (gap_q),
        .tick     (gap_tick),
        .expired  (gap_expired)
    );

    always_comb begin
        state_d  = state_q;
        cnt_inc  = 1'b0;
        capt     = 1'b0;
        gap_load = 1'b0;
        gap_tick = 1'b0;
`ifdef FAULT_ADDR_MASK_EN
        skip     = 1'b0;
`endif
        case (state_q)
            IDLE: if (cfg_start_i) state_d = (cfg_num_i == '0) ? DONE : SEED;
            SEED: state_d = STEP;
            STEP: state_d = CAPT;
            CAPT: begin
                capt    = 1'b1;
                state_d = ISSUE;
`ifdef FAULT_ADDR_MASK_EN
                if (addr_capt == '0) begin
                    capt    = 1'b0;
                    skip    = 1'b1;
                    state_d = (skip_cnt_q == SKIP_LAST) ? DONE : STEP;
                end
`endif
            end
            ISSUE: if (fault_ready_i) begin
                cnt_inc = 1'b1;
                if (cnt_next == num_q)  state_d = DONE;
                else if (gap_q == '0)   state_d = STEP;
                else begin
                    state_d  = GAP;
                    gap_load = 1'b1;
                end
            end
            GAP: begin
                gap_tick = 1'b1;
                if (gap_expired) state_d = STEP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a handshake in the same cycle.
        if (cfg_abort_i && state_q != IDLE) begin
            state_d  = IDLE;
            cnt_inc  = 1'b0;
            gap_load = 1'b0;
`ifdef FAULT_ADDR_MASK_EN
            skip     = 1'b0;
`endif
        end
    end

    // Outputs are decoded from the next state so they are flops aligned with state_q.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            num_q         <= '0;
            gap_q         <= '0;
            lfsr_seed_o   <= '0;
            lfsr_start_o  <= 1'b0;
            lfsr_en_o     <= 1'b0;
            fault_valid_o <= 1'b0;
            fault_addr_o  <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fault_cnt_o   <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_start_o  <= (state_d == SEED);
            lfsr_en_o     <= (state_d == STEP);
            fault_valid_o <= (state_d == ISSUE);
            busy_o        <= (state_d != IDLE);
            done_o        <= (state_d == DONE);
            if (start_ok) begin
                lfsr_seed_o <= cfg_seed_i;
                num_q       <= cfg_num_i;
                gap_q       <= cfg_gap_i;
                fault_cnt_o <= '0;
            end else if (cnt_inc) begin
                fault_cnt_o <= cnt_next;
            end
            if (capt) fault_addr_o <= addr_capt;
        end
    end

`ifdef FAULT_ADDR_MASK_EN
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            skip_cnt_q <= '0;
            skip_cap_o <= 1'b0;
        end else if (start_ok) begin
            skip_cnt_q <= '0;
            skip_cap_o <= 1'b0;
        end else if (skip) begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
            if (skip_cnt_q == SKIP_LAST) skip_cap_o <= 1'b1;
        end else if (capt) begin
            skip_cnt_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fault_inject_sched.sv
// Bench for fault_inject_sched: a behavioural LFSR stands in for the lfsr instance,
// campaigns come from a vector table, issued addresses are checked via a scoreboard queue.
module tb_fault_inject_sched;
    import fault_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cfg_start_i = 1'b0, cfg_abort_i = 1'b0, fault_ready_i = 1'b0;
    logic [7:0] cfg_seed_i = '0, cfg_num_i = '0, cfg_gap_i = '0;
    logic       lfsr_start_o, lfsr_en_o, fault_valid_o, busy_o, done_o;
    logic [7:0] lfsr_seed_o, lfsr_out, fault_addr_o, fault_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fault_inject_sched #(.N_bits(8), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .cfg_start_i   (cfg_start_i),
        .cfg_abort_i   (cfg_abort_i),
        .cfg_seed_i    (cfg_seed_i),
        .cfg_num_i     (cfg_num_i),
        .cfg_gap_i     (cfg_gap_i),
        .lfsr_start_o  (lfsr_start_o),
        .lfsr_en_o     (lfsr_en_o),
        .lfsr_seed_o   (lfsr_seed_o),
        .lfsr_out_i    (lfsr_out),
        .fault_valid_o (fault_valid_o),
        .fault_addr_o  (fault_addr_o),
        .fault_ready_i (fault_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .fault_cnt_o   (fault_cnt_o)
    );

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    logic [7:0] lfsr_q = 8'h00;
    always @(posedge clk) begin
        if (lfsr_start_o)   lfsr_q <= lfsr_seed_o;
        else if (lfsr_en_o) lfsr_q <= lfsr_step(lfsr_q);
    end
    assign lfsr_out = lfsr_q;

    typedef struct {
        logic [7:0] seed, num, gap;
        int stall_beat, stall_len, abort_beat;
        int exp_start, exp_done, exp_cnt, exp_beats;
    } tv_t;

    tv_t tv[8];

    function automatic tv_t mk(input logic [7:0] seed, num, gap, input int sb, sl, ab,
                               input int es, ed, ec, eb);
        tv_t t;
        t.seed = seed; t.num = num; t.gap = gap;
        t.stall_beat = sb; t.stall_len = sl; t.abort_beat = ab;
        t.exp_start = es; t.exp_done = ed; t.exp_cnt = ec; t.exp_beats = eb;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic run(input tv_t t, input int idx);
        int start_c, done_c, beats, stall_left, abort_c;
        bit fin, stalled;
        logic [7:0] a, hold_addr;
        fault_hs_t obs;
        start_c = -1; done_c = -1; beats = 0; stall_left = 0; abort_c = -1;
        fin = 0; stalled = 0; hold_addr = '0;
        a = t.seed;
        for (int k = 0; k < int'(t.num); k++) begin
            a = lfsr_step(a);
            exp_q.push_back(a);
        end
        @(negedge clk);
        cfg_seed_i = t.seed; cfg_num_i = t.num; cfg_gap_i = t.gap;
        cfg_start_i = 1'b1; cfg_abort_i = 1'b0; fault_ready_i = 1'b1;
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(negedge clk);
            cfg_start_i = 1'b0;
            cfg_abort_i = 1'b0;
            fault_ready_i = 1'b1;
            check($sformatf("v%0d_start_en_excl", idx), int'(lfsr_start_o & lfsr_en_o), 0);
            if (lfsr_start_o && start_c < 0) start_c = c;
            if (done_o && done_c < 0) done_c = c;
            if (abort_c >= 0 && c == abort_c + 1) begin
                check($sformatf("v%0d_abort_valid", idx), int'(fault_valid_o), 0);
                check($sformatf("v%0d_abort_busy", idx), int'(busy_o), 0);
            end
            if (stall_left > 0) begin
                check($sformatf("v%0d_stall_valid", idx), int'(fault_valid_o), 1);
                check($sformatf("v%0d_stall_addr", idx), int'(fault_addr_o), int'(hold_addr));
                check($sformatf("v%0d_stall_en", idx), int'(lfsr_en_o), 0);
                fault_ready_i = 1'b0;
                stall_left--;
            end else if (fault_valid_o) begin
                obs.valid = fault_valid_o;
                obs.addr  = fault_addr_o;
                if (beats == t.stall_beat && !stalled) begin
                    stalled = 1; hold_addr = obs.addr;
                    fault_ready_i = 1'b0;
                    stall_left = t.stall_len - 1;
                end else if (beats == t.abort_beat) begin
                    cfg_abort_i = 1'b1;
                    abort_c = c;
                    exp_q.delete();
                end else if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_beats_overrun", idx), beats + 1, int'(t.num));
                end else begin
                    check($sformatf("v%0d_addr%0d", idx, beats), int'(obs.addr), int'(exp_q.pop_front()));
                    beats++;
                end
            end
            if (!busy_o) fin = 1;
        end
        check($sformatf("v%0d_finished", idx), int'(fin), 1);
        check($sformatf("v%0d_start_cycle", idx), start_c, t.exp_start);
        check($sformatf("v%0d_done_cycle", idx), done_c, t.exp_done);
        check($sformatf("v%0d_beats", idx), beats, t.exp_beats);
        check($sformatf("v%0d_fault_cnt", idx), int'(fault_cnt_o), t.exp_cnt);
        check($sformatf("v%0d_sb_left", idx), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        tv[0] = mk(8'hAA, 4, 0, -1, 0, -1, 1, 14, 4, 4);
        tv[1] = mk(8'hAA, 4, 2, -1, 0, -1, 1, 20, 4, 4);
        tv[2] = mk(8'hAA, 4, 0,  1, 5, -1, 1, 19, 4, 4);
        tv[3] = mk(8'hAA, 0, 0, -1, 0, -1, -1, 1, 0, 0);
        tv[4] = mk(8'hAA, 4, 0, -1, 0,  2, 1, -1, 2, 2);
        tv[5] = mk(8'hAB, 3, 1, -1, 0, -1, 1, 13, 3, 3);
        tv[6] = mk(8'h5C, 6, 3, -1, 0, -1, 1, 35, 6, 6);
        tv[7] = mk(8'h01, 1, 0, -1, 0, -1, 1, 5, 1, 1);

        #12;
        check("rst_busy",  int'(busy_o), 0);
        check("rst_valid", int'(fault_valid_o), 0);
        check("rst_done",  int'(done_o), 0);
        check("rst_start", int'(lfsr_start_o), 0);
        check("rst_en",    int'(lfsr_en_o), 0);
        check("rst_seed",  int'(lfsr_seed_o), 0);
        check("rst_cnt",   int'(fault_cnt_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) run(tv[i], i);

        // async reset in the middle of a campaign, then a fresh campaign must reseed
        @(negedge clk);
        cfg_seed_i = 8'h33; cfg_num_i = 8'd5; cfg_gap_i = 8'd0;
        cfg_start_i = 1'b1; fault_ready_i = 1'b1;
        @(negedge clk);
        cfg_start_i = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_pre_busy", int'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy",  int'(busy_o), 0);
        check("mid_rst_valid", int'(fault_valid_o), 0);
        check("mid_rst_cnt",   int'(fault_cnt_o), 0);
        check("mid_rst_seed",  int'(lfsr_seed_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        run(tv[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
